// File: rtl/hi_trace_capture_if.sv
// Inputs (ADC sample, capture controls, major mode) and outputs (SSP serial
// stream, capture status) of the HF trace capture block.
interface hi_trace_capture_if #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 12
);
  logic [SAMPLE_W-1:0] adc_d;
  logic                trace_enable;
  logic                trigger;
  logic [2:0]          major_mode;
  logic                ssp_frame;
  logic                ssp_din;
  logic                ssp_clk;
  logic                trace_done;
  logic [ADDR_W:0]     valid_count;

  modport master (
    output adc_d, trace_enable, trigger, major_mode,
    input  ssp_frame, ssp_din, ssp_clk, trace_done, valid_count
  );

  modport slave (
    input  adc_d, trace_enable, trigger, major_mode,
    output ssp_frame, ssp_din, ssp_clk, trace_done, valid_count
  );
endinterface

// File: rtl/hi_trace_capture.sv
// Decimated ADC ring-buffer capture with trigger/post-count freeze, streamed oldest-first over SSP.
// Outputs registered on the falling clock edge; there is no backpressure, the SSP stream is free-running.
module hi_trace_capture #(
  parameter int         SAMPLE_W       = 8,
  parameter int         DEPTH          = 3072,
  parameter int         ADDR_W         = 12,
  parameter int         DECIM          = 8,
  parameter int         POST_SAMPLES   = 1024,
  parameter logic [2:0] MODE_OFF       = 3'd7,
  parameter logic [2:0] MODE_GET_TRACE = 3'd5
) (
  input logic               ck_1356megb,
  input logic               reset_n,
  hi_trace_capture_if.slave bus
);
  localparam int DEC_W = $clog2(DECIM);
  localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   POST_CNT  = (ADDR_W + 1)'(POST_SAMPLES);
  localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W + 1)'(1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {IDLE, ARMED, POST, FROZEN, READOUT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                wrapped_q, wrapped_d;
  logic [ADDR_W:0]     valid_count_q, valid_count_d;
  logic [ADDR_W:0]     post_cnt_q, post_cnt_d, words_q, words_d;
  logic [DEC_W-1:0]    dec_q, dec_d;
  logic [3:0]          ph_q, ph_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic                te_q, te_d;
  logic                trace_done_q, trace_done_d;
  logic                ssp_frame_q, ssp_frame_d, ssp_din_q, ssp_din_d, ssp_clk_q, ssp_clk_d;
  logic                wr_en, capture_mode, strobe, stop;
  logic [SAMPLE_W-1:0] cur_word, rd_dat;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wrapped_d     = wrapped_q;
    valid_count_d = valid_count_q;
    post_cnt_d    = post_cnt_q;
    words_d       = words_q;
    dec_d         = dec_q;
    ph_d          = ph_q;
    bit_d         = bit_q;
    sh_d          = sh_q;
    te_d          = bus.trace_enable;
    trace_done_d  = trace_done_q;
    ssp_frame_d   = 1'b0;
    ssp_din_d     = 1'b0;
    ssp_clk_d     = 1'b0;
    wr_en         = 1'b0;
    capture_mode  = (bus.major_mode != MODE_OFF) && (bus.major_mode != MODE_GET_TRACE);
    strobe        = (dec_q == '0);
    stop          = !bus.trace_enable || (bus.major_mode == MODE_OFF);
    cur_word      = (bit_q == '0) ? rd_dat : sh_q;

    if (bus.major_mode == MODE_GET_TRACE && state_q != READOUT) begin
      state_d   = READOUT;
      rd_addr_d = wrapped_q ? wr_addr_q : '0;
      words_d   = valid_count_q;
      ph_d      = '0;
      bit_d     = '0;
    end else begin
      unique case (state_q)
        IDLE, FROZEN: begin
          if (bus.trace_enable && !te_q && capture_mode) begin
            state_d       = ARMED;
            wr_addr_d     = '0;
            wrapped_d     = 1'b0;
            valid_count_d = '0;
            trace_done_d  = 1'b0;
            dec_d         = '0;
          end
        end
        ARMED, POST: begin
          // A manual stop wins over a same-cycle strobe: capture is only permitted while enabled.
          if (stop) begin
            state_d = FROZEN;
          end else begin
            dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
            if (strobe) begin
              wr_en     = 1'b1;
              wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
              if (wr_addr_q == LAST_ADDR) wrapped_d = 1'b1;
              if (valid_count_q != DEPTH_CNT) valid_count_d = valid_count_q + 1'b1;
            end
            if (state_q == ARMED) begin
              if (bus.trigger) begin
                if (POST_SAMPLES == 0) begin
                  state_d      = FROZEN;
                  trace_done_d = 1'b1;
                end else begin
                  state_d    = POST;
                  post_cnt_d = POST_CNT;
                end
              end
            end else if (strobe) begin
              post_cnt_d = post_cnt_q - 1'b1;
              if (post_cnt_q == ONE_CNT) begin
                state_d      = FROZEN;
                trace_done_d = 1'b1;
              end
            end
          end
        end
        READOUT: begin
          if (bus.major_mode != MODE_GET_TRACE) begin
            state_d = FROZEN;
          end else begin
            ph_d        = ph_q + 1'b1;
            ssp_clk_d   = ph_q[3];
            ssp_frame_d = ssp_frame_q;
            ssp_din_d   = ssp_din_q;
            // rd_dat is read from the next address, so the following word is already waiting.
            if (ph_q == 4'd0) begin
              ssp_frame_d = 1'b0;
              ssp_din_d   = 1'b0;
              if (words_q != '0) begin
                ssp_din_d   = cur_word[SAMPLE_W-1];
                ssp_frame_d = (bit_q == '0);
                sh_d        = cur_word << 1;
                if (bit_q == '0) rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
              end
            end
            if (ph_q == 4'd15 && words_q != '0) begin
              if (bit_q == BIT_LAST) begin
                bit_d   = '0;
                words_d = words_q - 1'b1;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge ck_1356megb) begin
    if (wr_en) mem[wr_addr_q] <= bus.adc_d;
    rd_dat <= mem[rd_addr_d];
  end

  always_ff @(negedge ck_1356megb or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wrapped_q     <= 1'b0;
      valid_count_q <= '0;
      post_cnt_q    <= '0;
      words_q       <= '0;
      dec_q         <= '0;
      ph_q          <= '0;
      bit_q         <= '0;
      sh_q          <= '0;
      te_q          <= 1'b0;
      trace_done_q  <= 1'b0;
      ssp_frame_q   <= 1'b0;
      ssp_din_q     <= 1'b0;
      ssp_clk_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wrapped_q     <= wrapped_d;
      valid_count_q <= valid_count_d;
      post_cnt_q    <= post_cnt_d;
      words_q       <= words_d;
      dec_q         <= dec_d;
      ph_q          <= ph_d;
      bit_q         <= bit_d;
      sh_q          <= sh_d;
      te_q          <= te_d;
      trace_done_q  <= trace_done_d;
      ssp_frame_q   <= ssp_frame_d;
      ssp_din_q     <= ssp_din_d;
      ssp_clk_q     <= ssp_clk_d;
    end
  end

  assign bus.ssp_frame   = ssp_frame_q;
  assign bus.ssp_din     = ssp_din_q;
  assign bus.ssp_clk     = ssp_clk_q;
  assign bus.trace_done  = trace_done_q;
  assign bus.valid_count = valid_count_q;
endmodule

// File: tb/tb_hi_trace_capture.sv
// Bench for hi_trace_capture: random ADC data, capture scenarios and SSP readout decoding
// against a sample-list reference model.
module tb_hi_trace_capture;
  localparam int SW = 8, DEPTH = 16, AW = 4, DECIM = 8;
  localparam logic [2:0] M_OFF = 3'd7, M_GET = 3'd5, M_CAP = 3'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hi_trace_capture_if #(.SAMPLE_W(SW), .ADDR_W(AW)) if_a ();
  hi_trace_capture_if #(.SAMPLE_W(SW), .ADDR_W(AW)) if_b ();

  hi_trace_capture #(.SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .DECIM(DECIM),
                     .POST_SAMPLES(4)) dut_a (.ck_1356megb(clk), .reset_n(rst_n), .bus(if_a));
  hi_trace_capture #(.SAMPLE_W(SW), .DEPTH(DEPTH), .ADDR_W(AW), .DECIM(DECIM),
                     .POST_SAMPLES(0)) dut_b (.ck_1356megb(clk), .reset_n(rst_n), .bus(if_b));

  int checks = 0, failures = 0;
  logic sel_b = 1'b0;
  logic o_fr, o_dn, o_ck, o_done;
  logic [AW:0] o_vcnt;
  assign o_fr   = sel_b ? if_b.ssp_frame   : if_a.ssp_frame;
  assign o_dn   = sel_b ? if_b.ssp_din     : if_a.ssp_din;
  assign o_ck   = sel_b ? if_b.ssp_clk     : if_a.ssp_clk;
  assign o_done = sel_b ? if_b.trace_done  : if_a.trace_done;
  assign o_vcnt = sel_b ? if_b.valid_count : if_a.valid_count;

  // Reference model: list of written samples plus capture bookkeeping.
  logic [SW-1:0] m_q[$];
  bit m_cap = 0, m_done = 0, m_te_prev = 0;
  int m_phase = 0, m_post_left = -1, m_post = 4;

  bit rec_on = 0;
  int rec_n = 0;
  logic rec_fr [4096];
  logic rec_dn [4096];
  logic rec_ck [4096];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int held();
    return (m_q.size() > DEPTH) ? DEPTH : m_q.size();
  endfunction

  // Drive one clock's inputs at posedge; the DUT samples them on the following negedge.
  task automatic step(input bit te, input bit trg, input logic [2:0] mm);
    logic [SW-1:0] d;
    @(posedge clk);
    if (rec_on && rec_n < 4096) begin
      rec_fr[rec_n] = o_fr; rec_dn[rec_n] = o_dn; rec_ck[rec_n] = o_ck;
      rec_n++;
    end
    d = SW'($urandom);
    if (sel_b) begin
      if_b.adc_d = d; if_b.trace_enable = te; if_b.trigger = trg; if_b.major_mode = mm;
      if_a.adc_d = '0; if_a.trace_enable = 1'b0; if_a.trigger = 1'b0; if_a.major_mode = M_OFF;
    end else begin
      if_a.adc_d = d; if_a.trace_enable = te; if_a.trigger = trg; if_a.major_mode = mm;
      if_b.adc_d = '0; if_b.trace_enable = 1'b0; if_b.trigger = 1'b0; if_b.major_mode = M_OFF;
    end
    if (m_cap) begin
      if (!te || mm == M_OFF || mm == M_GET) begin
        m_cap = 0;
      end else begin
        if (m_phase == 0) begin
          m_q.push_back(d);
          if (m_post_left > 0) begin
            m_post_left--;
            if (m_post_left == 0) begin m_cap = 0; m_done = 1; end
          end
        end
        if (trg && m_post_left < 0) begin
          if (m_post == 0) begin m_cap = 0; m_done = 1; end
          else m_post_left = m_post;
        end
        m_phase = (m_phase + 1) % DECIM;
      end
    end else if (te && !m_te_prev && mm != M_OFF && mm != M_GET) begin
      m_cap = 1; m_phase = 0; m_post_left = -1; m_done = 0;
      m_q.delete();
    end
    m_te_prev = te;
  endtask

  task automatic capture(input int n_pre, input bit do_trig, input int stop_at, input bit coincide);
    int guard;
    guard = 0;
    step(0, 0, M_CAP); step(0, 0, M_CAP);
    step(1, 0, M_CAP);
    while (m_q.size() < n_pre && guard < 1000) begin step(1, 0, M_CAP); guard++; end
    if (coincide) while (m_phase != 0 && guard < 1000) begin step(1, 0, M_CAP); guard++; end
    if (do_trig) begin
      step(1, 1, M_CAP);
      if (coincide) begin
        @(negedge clk); #1;
        chk("trig_edge_done", o_done, m_done);
        chk("trig_edge_vcnt", o_vcnt, held());
      end
      while (m_cap && m_post_left != stop_at && guard < 1000) begin step(1, 0, M_CAP); guard++; end
    end
    chk("cap_budget", guard < 1000, 1);
    if (m_cap) step(0, 0, M_CAP);
    else repeat (2 * DECIM) step(1, 0, M_CAP);
    repeat (2) step(0, 0, M_CAP);
  endtask

  task automatic readout(input int nclk);
    logic [SW-1:0] exp_w[$];
    logic [SW-1:0] w;
    int n, s, errs, idx;
    n = held();
    for (int i = m_q.size() - n; i < m_q.size(); i++) exp_w.push_back(m_q[i]);
    rec_n = 0; rec_on = 1;
    repeat (nclk) step(0, 0, M_GET);
    rec_on = 0;
    s = -1;
    for (int i = 1; i < rec_n; i++) if (s < 0 && rec_ck[i] && !rec_ck[i-1]) s = i - 8;
    chk("rd_clk_seen", s >= 0, 1);
    if (s >= 0) begin
      errs = 0;
      for (int i = 0; i < rec_n; i++) begin
        int c, k, wi, b;
        logic e_ck, e_fr, e_dn;
        e_ck = 1'b0; e_fr = 1'b0; e_dn = 1'b0;
        if (i >= s) begin
          c = (i - s) % 16; k = (i - s) / 16; wi = k / SW; b = k % SW;
          e_ck = (c >= 8);
          if (wi < n) begin e_fr = (b == 0); e_dn = exp_w[wi][SW-1-b]; end
        end
        if (rec_ck[i] !== e_ck || rec_fr[i] !== e_fr || rec_dn[i] !== e_dn) errs++;
      end
      chk("rd_shape_errs", errs, 0);
      for (int wi = 0; wi < n; wi++) begin
        w = '0;
        for (int b = 0; b < SW; b++) begin
          idx = s + (wi * SW + b) * 16 + 8;
          if (idx < rec_n) w = {w[SW-2:0], rec_dn[idx]};
        end
        chk("rd_word", w, exp_w[wi]);
      end
    end
    step(0, 0, M_CAP);
    @(negedge clk); #1;
    chk("exit_frame", o_fr, 0);
    chk("exit_din", o_dn, 0);
    chk("exit_clk", o_ck, 0);
  endtask

  initial begin
    if_a.adc_d = '0; if_a.trace_enable = 1'b0; if_a.trigger = 1'b0; if_a.major_mode = M_OFF;
    if_b.adc_d = '0; if_b.trace_enable = 1'b0; if_b.trigger = 1'b0; if_b.major_mode = M_OFF;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vcnt", o_vcnt, 0);
    chk("rst_done", o_done, 0);
    chk("rst_frame", o_fr, 0);
    chk("rst_din", o_dn, 0);
    chk("rst_clk", o_ck, 0);
    @(posedge clk); rst_n = 1'b1;
    repeat (4) step(0, 0, M_CAP);
    @(negedge clk); #1;
    chk("idle_vcnt", o_vcnt, 0);
    chk("idle_clk", o_ck, 0);

    // Trigger after 10 writes: 4 post writes then freeze.
    capture(10, 1, -1, 0);
    chk("s1_done", o_done, m_done);
    chk("s1_vcnt", o_vcnt, held());

    // Trigger after 20 writes: buffer wraps, readout of the newest 16, repeatable.
    capture(20, 1, -1, 0);
    chk("s2_done", o_done, m_done);
    chk("s2_vcnt", o_vcnt, held());
    readout(16 * SW * 16 + 40);
    chk("s2_done_keep", o_done, m_done);
    chk("s2_vcnt_keep", o_vcnt, held());
    readout(16 * SW * 16 + 40);

    // Manual stop after 3 writes, then a short stream with idle tail.
    capture(3, 0, -1, 0);
    chk("s3_done", o_done, m_done);
    chk("s3_vcnt", o_vcnt, held());
    readout(3 * SW * 16 + 200);

    // Drop enable mid-POST with 2 post samples still outstanding; later trigger ignored.
    capture(6, 1, 2, 0);
    chk("s4_done", o_done, m_done);
    chk("s4_vcnt", o_vcnt, held());
    step(0, 1, M_CAP);
    repeat (2 * DECIM) step(0, 0, M_CAP);
    @(negedge clk); #1;
    chk("s4_late_trig_done", o_done, m_done);
    chk("s4_late_trig_vcnt", o_vcnt, held());

    // Zero post samples, trigger on a strobe clock.
    sel_b = 1'b1; m_post = 0; m_te_prev = 0;
    capture(5, 1, -1, 1);
    chk("s5_done", o_done, m_done);
    chk("s5_vcnt", o_vcnt, held());
    readout(held() * SW * 16 + 40);

    // Asynchronous reset mid-readout, then re-enter readout with nothing held.
    repeat (300) step(0, 0, M_GET);
    #2 rst_n = 1'b0;
    #1;
    m_q.delete(); m_cap = 0; m_done = 0; m_te_prev = 0;
    chk("s6_rst_frame", o_fr, 0);
    chk("s6_rst_din", o_dn, 0);
    chk("s6_rst_clk", o_ck, 0);
    chk("s6_rst_vcnt", o_vcnt, 0);
    chk("s6_rst_done", o_done, 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    readout(300);
    chk("s6_vcnt", o_vcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
